alu_issue_stage: RTL and testbench

//  DLX execute-issue stage directly upstream of the 32-bit ALU (sel0..sel5 op select).

---
 rtl/alu_issue_stage.sv | 169 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// DLX execute-issue stage: decodes opcode/func into ALU selects, picks in2, and registers
// everything through a 2-entry skid buffer. Optional build macro: ALU_ISSUE_ILLEGAL_TRAP_EN.
module alu_issue_stage #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        opcode,
  input  logic [5:0]        func,
  input  logic [DATA_W-1:0] rs1_val,
  input  logic [DATA_W-1:0] rs2_val,
  input  logic [15:0]       imm16,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [5:0]        alu_sel
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  ,
  output logic              illegal_seen
`endif
);

  // Handshake: a beat moves on a side when valid and ready are both high at the rising edge;
  // valid never depends on ready, and the output registers hold while out_valid & !out_ready.

  localparam logic [5:0] SEL_AND = 6'b000000;
  localparam logic [5:0] SEL_OR  = 6'b000001;
  localparam logic [5:0] SEL_XOR = 6'b000010;
  localparam logic [5:0] SEL_SLL = 6'b000110;
  localparam logic [5:0] SEL_SRA = 6'b000100;
  localparam logic [5:0] SEL_SRL = 6'b000101;
  localparam logic [5:0] SEL_ADD = 6'b100000;
  localparam logic [5:0] SEL_SUB = 6'b111000;
  localparam logic [5:0] SEL_SEQ = 6'b110000;
  localparam logic [5:0] SEL_SNE = 6'b110001;
  localparam logic [5:0] SEL_SLT = 6'b110010;
  localparam logic [5:0] SEL_SGT = 6'b110011;
  localparam logic [5:0] SEL_SLE = 6'b110100;
  localparam logic [5:0] SEL_SGE = 6'b110110;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]        state, state_next;
  logic [5:0]        dec_sel;
  logic [DATA_W-1:0] dec_in2;
  logic              dec_legal;
  logic [DATA_W-1:0] imm_sext, imm_zext, shamt_reg, shamt_imm;
  logic [DATA_W-1:0] skid_in1, skid_in2;
  logic [5:0]        skid_sel;
  logic              push, pop;

  assign imm_sext  = {{(DATA_W-16){imm16[15]}}, imm16};
  assign imm_zext  = {{(DATA_W-16){1'b0}}, imm16};
  assign shamt_reg = {{(DATA_W-SHAMT_W){1'b0}}, rs2_val[SHAMT_W-1:0]};
  assign shamt_imm = {{(DATA_W-SHAMT_W){1'b0}}, imm16[SHAMT_W-1:0]};

  always_comb begin
    dec_sel   = SEL_ADD;
    dec_in2   = '0;
    dec_legal = 1'b1;
    if (opcode == 6'h00) begin
      dec_in2 = rs2_val;
      case (func)
        6'h20: dec_sel = SEL_ADD;
        6'h22: dec_sel = SEL_SUB;
        6'h24: dec_sel = SEL_AND;
        6'h25: dec_sel = SEL_OR;
        6'h26: dec_sel = SEL_XOR;
        6'h04: begin dec_sel = SEL_SLL; dec_in2 = shamt_reg; end
        6'h06: begin dec_sel = SEL_SRL; dec_in2 = shamt_reg; end
        6'h07: begin dec_sel = SEL_SRA; dec_in2 = shamt_reg; end
        6'h28: dec_sel = SEL_SEQ;
        6'h29: dec_sel = SEL_SNE;
        6'h2A: dec_sel = SEL_SLT;
        6'h2B: dec_sel = SEL_SGT;
        6'h2C: dec_sel = SEL_SLE;
        6'h2D: dec_sel = SEL_SGE;
        default: begin dec_legal = 1'b0; dec_sel = SEL_ADD; dec_in2 = '0; end
      endcase
    end else begin
      dec_in2 = imm_sext;
      case (opcode)
        6'h08: dec_sel = SEL_ADD;
        6'h0A: dec_sel = SEL_SUB;
        6'h0C: begin dec_sel = SEL_AND; dec_in2 = imm_zext; end
        6'h0D: begin dec_sel = SEL_OR;  dec_in2 = imm_zext; end
        6'h0E: begin dec_sel = SEL_XOR; dec_in2 = imm_zext; end
        6'h14: begin dec_sel = SEL_SLL; dec_in2 = shamt_imm; end
        6'h16: begin dec_sel = SEL_SRL; dec_in2 = shamt_imm; end
        6'h17: begin dec_sel = SEL_SRA; dec_in2 = shamt_imm; end
        6'h18: dec_sel = SEL_SEQ;
        6'h19: dec_sel = SEL_SNE;
        6'h1A: dec_sel = SEL_SLT;
        6'h1B: dec_sel = SEL_SGT;
        6'h1C: dec_sel = SEL_SLE;
        6'h1D: dec_sel = SEL_SGE;
        default: begin dec_legal = 1'b0; dec_sel = SEL_ADD; dec_in2 = '0; end
      endcase
    end
  end

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  // Illegal ops are consumed upstream but never enter the buffer.
  assign push = in_valid & in_ready & dec_legal;
`else
  assign push = in_valid & in_ready;
`endif
  assign pop       = out_valid & out_ready;
  assign out_valid = (state != ST_EMPTY);

  always_comb begin
    state_next = state;
    case (state)
      ST_EMPTY: if (push) state_next = ST_ONE;
      ST_ONE: begin
        if (push && !pop)      state_next = ST_FULL;
        else if (pop && !push) state_next = ST_EMPTY;
      end
      ST_FULL:  if (pop) state_next = ST_ONE;
      default:  state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b1;
      alu_in1  <= '0;
      alu_in2  <= '0;
      alu_sel  <= '0;
      skid_in1 <= '0;
      skid_in2 <= '0;
      skid_sel <= '0;
    end else begin
      state    <= state_next;
      in_ready <= (state_next != ST_FULL);
      case (state)
        ST_EMPTY: if (push) begin
          alu_in1 <= rs1_val; alu_in2 <= dec_in2; alu_sel <= dec_sel;
        end
        ST_ONE: begin
          if (push && pop) begin
            alu_in1 <= rs1_val; alu_in2 <= dec_in2; alu_sel <= dec_sel;
          end else if (push) begin
            skid_in1 <= rs1_val; skid_in2 <= dec_in2; skid_sel <= dec_sel;
          end
        end
        ST_FULL: if (pop) begin
          alu_in1 <= skid_in1; alu_in2 <= skid_in2; alu_sel <= skid_sel;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) illegal_seen <= 1'b0;
    else if (in_valid && in_ready && !dec_legal) illegal_seen <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: vector table through a scoreboard queue,
// plus backpressure, reset-while-full and illegal-op sequences.
module tb_alu_issue_stage;

  typedef struct {
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [15:0] imm;
    logic [5:0]  sel;
    logic [31:0] in2;
    bit          legal;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [5:0]  opcode, func, alu_sel;
  logic [31:0] rs1_val, rs2_val, alu_in1, alu_in2;
  logic [15:0] imm16;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  logic        illegal_seen;
`endif

  logic [69:0] exp_q[$];
  vec_t        vecs[$];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.DATA_W(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .func(func), .rs1_val(rs1_val), .rs2_val(rs2_val), .imm16(imm16),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_sel(alu_sel)
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    , .illegal_seen(illegal_seen)
`endif
  );

  function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] a,
                              input logic [31:0] b, input logic [15:0] imm, input logic [5:0] sel,
                              input logic [31:0] in2, input bit legal);
    vec_t v;
    v.opcode = op; v.func = fn; v.rs1 = a; v.rs2 = b; v.imm = imm;
    v.sel = sel; v.in2 = in2; v.legal = legal;
    return v;
  endfunction

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, then score what the coming posedge will transfer.
  task automatic step(input logic iv, input vec_t v, input logic ordy, output logic acc);
    logic [69:0] e;
    @(negedge clk);
    in_valid = iv; opcode = v.opcode; func = v.func; rs1_val = v.rs1;
    rs2_val = v.rs2; imm16 = v.imm; out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_output sel=%b in1=%h in2=%h required=none", alu_sel, alu_in1, alu_in2);
      end else begin
        e = exp_q.pop_front();
        check("output", {alu_sel, alu_in1, alu_in2}, e);
      end
    end
    acc = iv && in_ready;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    if (acc && v.legal) exp_q.push_back({v.sel, v.rs1, v.in2});
`else
    if (acc) exp_q.push_back({v.sel, v.rs1, v.in2});
`endif
  endtask

  task automatic send(input vec_t v, input bit rand_ready);
    logic acc;
    int   tries;
    acc = 1'b0;
    tries = 0;
    if (rand_ready && $urandom_range(0, 3) == 0) step(1'b0, v, 1'($urandom_range(0, 1)), acc);
    acc = 1'b0;
    while (!acc && tries < 50) begin
      step(1'b1, v, rand_ready ? 1'($urandom_range(0, 1)) : 1'b1, acc);
      tries++;
    end
    if (!acc) begin
      total++; bad++;
      $display("FAIL accept_timeout actual=0 required=1");
    end
  endtask

  task automatic drain();
    logic acc;
    vec_t idle;
    idle = mk(6'h00, 6'h20, 0, 0, 0, 6'b100000, 0, 1'b1);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1'b0, idle, 1'b1, acc);
    check("drain_empty", 70'(exp_q.size()), 70'd0);
  endtask

  initial begin
    logic acc;
    vec_t va, vb, vc;

    vecs.push_back(mk(6'h00, 6'h20, 32'd5,        32'd7,        16'h0000, 6'b100000, 32'd7,        1'b1));
    vecs.push_back(mk(6'h0C, 6'h00, 32'h12345678, 32'h0,        16'hFFFF, 6'b000000, 32'h0000FFFF, 1'b1));
    vecs.push_back(mk(6'h08, 6'h00, 32'd1,        32'h0,        16'hFFFF, 6'b100000, 32'hFFFFFFFF, 1'b1));
    vecs.push_back(mk(6'h14, 6'h00, 32'hF0F0F0F0, 32'h0,        16'h0023, 6'b000110, 32'h00000003, 1'b1));
    vecs.push_back(mk(6'h00, 6'h07, 32'h80000000, 32'hFFFFFFE4, 16'h1234, 6'b000100, 32'h00000004, 1'b1));
    vecs.push_back(mk(6'h00, 6'h22, 32'd100,      32'd9,        16'h0000, 6'b111000, 32'd9,        1'b1));
    vecs.push_back(mk(6'h0D, 6'h00, 32'hA5A5A5A5, 32'h0,        16'h8001, 6'b000001, 32'h00008001, 1'b1));
    vecs.push_back(mk(6'h0E, 6'h00, 32'h1,        32'h0,        16'h1234, 6'b000010, 32'h00001234, 1'b1));
    vecs.push_back(mk(6'h16, 6'h00, 32'h2,        32'h0,        16'hFFFF, 6'b000101, 32'h0000001F, 1'b1));
    vecs.push_back(mk(6'h1A, 6'h00, 32'h3,        32'h0,        16'h8000, 6'b110010, 32'hFFFF8000, 1'b1));
    vecs.push_back(mk(6'h00, 6'h2D, 32'h4,        32'hAAAA5555, 16'h0000, 6'b110110, 32'hAAAA5555, 1'b1));
    vecs.push_back(mk(6'h00, 6'h04, 32'h5,        32'h00000021, 16'h0000, 6'b000110, 32'h00000001, 1'b1));
    vecs.push_back(mk(6'h00, 6'h29, 32'h6,        32'h0BADF00D, 16'h0000, 6'b110001, 32'h0BADF00D, 1'b1));
    vecs.push_back(mk(6'h1D, 6'h00, 32'h7,        32'h0,        16'h7FFF, 6'b110110, 32'h00007FFF, 1'b1));
    vecs.push_back(mk(6'h18, 6'h00, 32'h8,        32'h0,        16'hFFFE, 6'b110000, 32'hFFFFFFFE, 1'b1));
    vecs.push_back(mk(6'h19, 6'h00, 32'h9,        32'h0,        16'h0010, 6'b110001, 32'h00000010, 1'b1));
    vecs.push_back(mk(6'h1B, 6'h00, 32'hA,        32'h0,        16'h9000, 6'b110011, 32'hFFFF9000, 1'b1));
    vecs.push_back(mk(6'h1C, 6'h00, 32'hB,        32'h0,        16'h0001, 6'b110100, 32'h00000001, 1'b1));
    vecs.push_back(mk(6'h0A, 6'h00, 32'hC,        32'h0,        16'hFFF0, 6'b111000, 32'hFFFFFFF0, 1'b1));
    vecs.push_back(mk(6'h17, 6'h00, 32'hD,        32'h0,        16'hFFE8, 6'b000100, 32'h00000008, 1'b1));
    vecs.push_back(mk(6'h00, 6'h24, 32'hE,        32'h12345678, 16'h0000, 6'b000000, 32'h12345678, 1'b1));
    vecs.push_back(mk(6'h00, 6'h25, 32'hF,        32'h00FF00FF, 16'h0000, 6'b000001, 32'h00FF00FF, 1'b1));
    vecs.push_back(mk(6'h00, 6'h26, 32'h10,       32'h11111111, 16'h0000, 6'b000010, 32'h11111111, 1'b1));
    vecs.push_back(mk(6'h00, 6'h06, 32'h11,       32'hFFFFFFFF, 16'h0000, 6'b000101, 32'h0000001F, 1'b1));
    vecs.push_back(mk(6'h00, 6'h28, 32'h12,       32'h22222222, 16'h0000, 6'b110000, 32'h22222222, 1'b1));
    vecs.push_back(mk(6'h00, 6'h2A, 32'h13,       32'h33333333, 16'h0000, 6'b110010, 32'h33333333, 1'b1));
    vecs.push_back(mk(6'h00, 6'h2B, 32'h14,       32'h44444444, 16'h0000, 6'b110011, 32'h44444444, 1'b1));
    vecs.push_back(mk(6'h00, 6'h2C, 32'h15,       32'h55555555, 16'h0000, 6'b110100, 32'h55555555, 1'b1));
    vecs.push_back(mk(6'h00, 6'h3F, 32'hDEADBEEF, 32'h66666666, 16'h0000, 6'b100000, 32'h00000000, 1'b0));
    vecs.push_back(mk(6'h3F, 6'h20, 32'hCAFEF00D, 32'h77777777, 16'h1234, 6'b100000, 32'h00000000, 1'b0));

    // clock/reset
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; opcode = '0; func = '0;
    rs1_val = '0; rs2_val = '0; imm16 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", {65'd0, out_valid, in_ready, alu_sel[0], 2'b0} | 70'(alu_in1 | alu_in2 | 32'(alu_sel)) << 5,
          {65'd0, 1'b0, 1'b1, 1'b0, 2'b0});
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    check("reset_illegal_seen", 70'(illegal_seen), 70'd0);
`endif
    rst = 1'b0;

    // pass 1: out_ready held high, back to back
    foreach (vecs[i]) send(vecs[i], 1'b0);
    drain();
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    check("illegal_seen_set", 70'(illegal_seen), 70'd1);
`endif

    // pass 2: random bubbles and random out_ready
    foreach (vecs[i]) send(vecs[i], 1'b1);
    drain();

    // backpressure: two accepts fill the buffer, third waits
    va = vecs[0]; vb = vecs[1]; vc = vecs[2];
    step(1'b1, va, 1'b0, acc);
    check("bp_accept1", 70'(acc), 70'd1);
    step(1'b1, vb, 1'b0, acc);
    check("bp_accept2", 70'(acc), 70'd1);
    step(1'b1, vc, 1'b0, acc);
    check("bp_in_ready_low", {68'd0, in_ready, out_valid}, {68'd0, 1'b0, 1'b1});
    check("bp_head_hold1", {alu_sel, alu_in1, alu_in2}, exp_q[0]);
    step(1'b1, vc, 1'b0, acc);
    check("bp_head_hold2", {alu_sel, alu_in1, alu_in2}, exp_q[0]);
    check("bp_queue_depth", 70'(exp_q.size()), 70'd2);
    acc = 1'b0;
    for (int i = 0; i < 5 && !acc; i++) step(1'b1, vc, 1'b1, acc);
    check("bp_third_accepted", 70'(acc), 70'd1);
    drain();

    // reset while full
    step(1'b1, vecs[5], 1'b0, acc);
    step(1'b1, vecs[6], 1'b0, acc);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("rst_full_ctrl", {68'd0, out_valid, in_ready}, {68'd0, 1'b0, 1'b1});
    check("rst_full_data", {alu_sel, alu_in1, alu_in2}, 70'd0);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    check("rst_illegal_seen", 70'(illegal_seen), 70'd0);
`endif
    exp_q.delete();
    for (int i = 0; i < 4; i++) step(1'b0, vecs[0], 1'b1, acc);
    check("rst_nothing_emitted", 70'(out_valid), 70'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
